bcd_serial_add_ctrl: RTL and testbench

//  Digit-serial controller for the BCD adder datapath: adds two DIGITS-wide packed BCD

---
 rtl/bcd_serial_add_ctrl.sv | 128 ++++++++++++
 tb/tb_bcd_serial_add_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// rtl/bcd_serial_add_ctrl.sv - digit-serial packed BCD adder controller, one digit per clock, LSB first
// Optional invalid-digit detection when BCD_DIGIT_CHECK_EN is defined.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [W-1:0]    a_sh;
  logic [W-1:0]    b_sh;
  logic [W-1:0]    acc;
  logic [W-1:0]    acc_nxt;
  logic            carry;
  logic [CW-1:0]   count;
  logic [4:0]      t;
  logic            f;
  logic [3:0]      digit;
  logic            last;
  logic            accept;

  assign t      = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
  assign f      = t[4] | (t[3] & (t[2] | t[1]));
  assign digit  = f ? (t[3:0] + 4'd6) : t[3:0];
  assign last   = (count == CW'(DIGITS - 1));
  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  // Result digits enter at the MSB end so digit0 lands at the bottom after DIGITS shifts.
  generate
    if (DIGITS == 1) begin : g_one
      assign acc_nxt = digit;
    end else begin : g_many
      assign acc_nxt = {digit, acc[W-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE:            state_nxt = IDLE;
      default:         state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 4;
      b_sh  <= b_sh >> 4;
      carry <= f;
      acc   <= acc_nxt;
      count <= count + 1'b1;
      if (last) begin
        sum  <= acc_nxt;
        cout <= f;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_seen;
  logic bad_now;
  logic err_q;

  assign bad_now = (a_sh[3:0] > 4'd9) || (b_sh[3:0] > 4'd9);
  assign err     = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_seen <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      bad_seen <= 1'b0;
      err_q    <= 1'b0;
    end else if (state == RUN) begin
      bad_seen <= bad_seen | bad_now;
      if (last) err_q <= bad_seen | bad_now;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb/tb_bcd_serial_add_ctrl.sv - scoreboard bench for bcd_serial_add_ctrl (DIGITS=4)
// Expected results come from decimal integer arithmetic on the operands.
module tb_bcd_serial_add_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;
`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         err;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .err  (err)
  );

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         err;
    int           acc_cyc;
    bit           chk_sum;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   next_ok     = 0;
  int   bcnt        = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint bcd2int(input logic [W-1:0] v);
    longint r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input longint x);
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit all_bcd(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // The model only knows the handshake rule: a start is taken if the block has
  // been back in IDLE long enough since the previous acceptance.
  task automatic drive(input bit s, input logic [W-1:0] av, input logic [W-1:0] bv, input bit c);
    exp_t   e;
    longint lim;
    longint tot;
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    cin   = c;
    if (s && rst_n && (cyc + 1 >= next_ok)) begin
      lim       = 1;
      for (int i = 0; i < D; i++) lim = lim * 10;
      tot       = bcd2int(av) + bcd2int(bv) + longint'(c);
      e.sum     = int2bcd(tot % lim);
      e.cout    = (tot >= lim);
      e.chk_sum = all_bcd(av) && all_bcd(bv);
      e.err     = CHK_EN && !e.chk_sum;
      e.acc_cyc = cyc + 1;
      q.push_back(e);
      next_ok   = cyc + 1 + D + 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      bcnt = 0;
    end else begin
      if (busy) bcnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = q.pop_front();
          if (e.chk_sum) chk("sum", 64'(sum), 64'(e.sum));
          if (e.chk_sum) chk("cout", 64'(cout), 64'(e.cout));
          chk("err", 64'(err), 64'(e.err));
          chk("latency", 64'(cyc), 64'(e.acc_cyc + D));
          chk("busy_cycles", 64'(bcnt), 64'(D));
          chk("busy_in_done", 64'(busy), 64'(0));
        end
        bcnt = 0;
      end
    end
  end

  initial begin
    int guard;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_sum", 64'(sum), 64'(0));
    chk("rst_cout", 64'(cout), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    rst_n = 1'b1;

    drive(1'b1, 16'h1234, 16'h5678, 1'b0); idle(8);
    drive(1'b1, 16'h9999, 16'h0001, 1'b0); idle(8);
    drive(1'b1, 16'h0000, 16'h0000, 1'b1); idle(8);
    drive(1'b1, 16'h9999, 16'h9999, 1'b1); idle(8);

    for (int i = 0; i < 40; i++) drive(1'b1, rand_bcd(), rand_bcd(), 1'($urandom));
    idle(8);
    for (int i = 0; i < 300; i++) drive(1'($urandom_range(0, 1)), rand_bcd(), rand_bcd(), 1'($urandom));
    idle(8);

    drive(1'b1, 16'h4444, 16'h5555, 1'b0);
    idle(2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_sum", 64'(sum), 64'(0));
    chk("abort_cout", 64'(cout), 64'(0));
    chk("abort_err", 64'(err), 64'(0));
    if (q.size() > 0) void'(q.pop_back());
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    next_ok = 0;
    drive(1'b1, 16'h0005, 16'h0005, 1'b0); idle(8);

    drive(1'b1, 16'h00A0, 16'h0001, 1'b0); idle(8);
    drive(1'b1, 16'h0001, 16'h0001, 1'b0); idle(8);

    guard = 0;
    while (q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_pending", 64'(q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
